// File: rtl/alu_seq_shift_unit.sv
// rtl/alu_seq_shift_unit.sv - WIDTH-bit ALU with one-cycle arith/logic and bit-serial shift/rotate
module alu_seq_shift_unit #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op_in,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             c_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] res_out,
  output logic             res_we,
  output logic [3:0]       flags_out
);

  // Count register must hold values 0..WIDTH; the extended count field is
  // wide enough to compare against WIDTH and WIDTH+1 without truncation.
  localparam int CW = $clog2(WIDTH + 1);
  localparam int EW = CNT_W + CW;
  localparam logic [EW-1:0] W_E  = EW'(WIDTH);
  localparam logic [EW-1:0] W1_E = EW'(WIDTH + 1);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_ADC  = 4'd1;
  localparam logic [3:0] OP_SUB  = 4'd2;
  localparam logic [3:0] OP_SBC  = 4'd3;
  localparam logic [3:0] OP_CMP  = 4'd4;
  localparam logic [3:0] OP_AND  = 4'd5;
  localparam logic [3:0] OP_ORR  = 4'd6;
  localparam logic [3:0] OP_XOR  = 4'd7;
  localparam logic [3:0] OP_LSL  = 4'd8;
  localparam logic [3:0] OP_LSR  = 4'd9;
  localparam logic [3:0] OP_ASR  = 4'd10;
  localparam logic [3:0] OP_ROL  = 4'd11;
  localparam logic [3:0] OP_ROR  = 4'd12;
  localparam logic [3:0] OP_ROLC = 4'd13;
  localparam logic [3:0] OP_RORC = 4'd14;
  localparam logic [3:0] OP_RSVD = 4'd15;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [3:0]       op_q, op_d;
  logic [WIDTH-1:0] val_q, val_d;
  logic             car_q, car_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [3:0]       flags_q, flags_d;
  logic             res_we_q, res_we_d;

  logic [EW-1:0]    b_ext;
  logic [EW-1:0]    eff;
  logic             is_shift;

  logic [WIDTH-1:0] op2;
  logic             cin;
  logic [WIDTH:0]   sum;
  logic             ovf;
  logic [WIDTH-1:0] imm_res;
  logic             imm_c;
  logic             imm_v;
  logic             imm_we;
  logic [3:0]       imm_flags;

  logic [WIDTH-1:0] step_val;
  logic             step_car;
  logic [3:0]       step_flags;

  // Effective shift/rotate count of the op presented at the input
  always_comb begin
    b_ext    = EW'(b_in[CNT_W-1:0]);
    eff      = '0;
    is_shift = 1'b0;
    case (op_in)
      OP_LSL, OP_LSR, OP_ASR: begin
        is_shift = 1'b1;
        eff      = (b_ext > W_E) ? W_E : b_ext;
      end
      OP_ROL, OP_ROR: begin
        is_shift = 1'b1;
        eff      = b_ext & (W_E - EW'(1));
      end
      OP_ROLC, OP_RORC: begin
        // Carry takes part in the rotation, so the ring is WIDTH+1 bits long
        is_shift = 1'b1;
        eff      = b_ext % W1_E;
      end
      default: ;
    endcase
  end

  // Single-cycle result: add/sub share one adder, subtraction as a + ~b + cin
  always_comb begin
    op2 = b_in;
    cin = 1'b0;
    case (op_in)
      OP_ADC:         cin = c_in;
      OP_SUB, OP_CMP: begin op2 = ~b_in; cin = 1'b1; end
      OP_SBC:         begin op2 = ~b_in; cin = c_in; end
      default: ;
    endcase
    sum = {1'b0, a_in} + {1'b0, op2} + {{WIDTH{1'b0}}, cin};
    ovf = (a_in[WIDTH-1] == op2[WIDTH-1]) && (sum[WIDTH-1] != a_in[WIDTH-1]);

    // Shift ops with a zero count fall through to the default: result=a, C=c_in
    imm_res = a_in;
    imm_c   = c_in;
    imm_v   = 1'b0;
    imm_we  = 1'b1;
    case (op_in)
      OP_ADD, OP_ADC, OP_SUB, OP_SBC, OP_CMP: begin
        imm_res = sum[WIDTH-1:0];
        imm_c   = sum[WIDTH];
        imm_v   = ovf;
        imm_we  = (op_in != OP_CMP);
      end
      OP_AND:  imm_res = a_in & b_in;
      OP_ORR:  imm_res = a_in | b_in;
      OP_XOR:  imm_res = a_in ^ b_in;
      OP_RSVD: imm_we  = 1'b0;
      default: ;
    endcase
    imm_flags = {imm_res[WIDTH-1], imm_v, (imm_res == '0), imm_c};
  end

  // One bit position of shift/rotate per cycle on the latched working value
  always_comb begin
    step_val = val_q;
    step_car = car_q;
    case (op_q)
      OP_LSL:  begin step_car = val_q[WIDTH-1]; step_val = {val_q[WIDTH-2:0], 1'b0}; end
      OP_LSR:  begin step_car = val_q[0];       step_val = {1'b0, val_q[WIDTH-1:1]}; end
      OP_ASR:  begin step_car = val_q[0];       step_val = {val_q[WIDTH-1], val_q[WIDTH-1:1]}; end
      OP_ROL:  begin step_car = val_q[WIDTH-1]; step_val = {val_q[WIDTH-2:0], val_q[WIDTH-1]}; end
      OP_ROR:  begin step_car = val_q[0];       step_val = {val_q[0], val_q[WIDTH-1:1]}; end
      OP_ROLC: begin step_car = val_q[WIDTH-1]; step_val = {val_q[WIDTH-2:0], car_q}; end
      OP_RORC: begin step_car = val_q[0];       step_val = {car_q, val_q[WIDTH-1:1]}; end
      default: ;
    endcase
    step_flags = {step_val[WIDTH-1], 1'b0, (step_val == '0), step_car};
  end

  // Next-state, datapath load and handshake outputs
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    val_d     = val_q;
    car_d     = car_q;
    cnt_d     = cnt_q;
    res_d     = res_q;
    flags_d   = flags_q;
    res_we_d  = res_we_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          op_d  = op_in;
          val_d = a_in;
          car_d = c_in;
          cnt_d = eff[CW-1:0];
          if (is_shift && (eff != '0)) begin
            state_d = S_SHIFT;
          end else begin
            state_d  = S_DONE;
            res_d    = imm_res;
            flags_d  = imm_flags;
            res_we_d = imm_we;
          end
        end
      end
      S_SHIFT: begin
        val_d = step_val;
        car_d = step_car;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d  = S_DONE;
          res_d    = step_val;
          flags_d  = step_flags;
          res_we_d = 1'b1;
        end
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any op in flight
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      val_q    <= '0;
      car_q    <= 1'b0;
      cnt_q    <= '0;
      res_q    <= '0;
      flags_q  <= '0;
      res_we_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      val_q    <= val_d;
      car_q    <= car_d;
      cnt_q    <= cnt_d;
      res_q    <= res_d;
      flags_q  <= flags_d;
      res_we_q <= res_we_d;
    end
  end

  assign res_out   = res_q;
  assign flags_out = flags_q;
  assign res_we    = res_we_q;

endmodule

// File: tb/tb_alu_seq_shift_unit.sv
// tb/tb_alu_seq_shift_unit.sv - randomized and directed check of alu_seq_shift_unit against a reference model
module tb_alu_seq_shift_unit;

  logic       clk;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] op_in;
  logic [7:0] a_in;
  logic [7:0] b_in;
  logic       c_in;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] res_out;
  logic       res_we;
  logic [3:0] flags_out;

  int total;
  int bad;

  typedef struct {
    logic [7:0] r;
    logic [3:0] f;
    logic       we;
    int         lat;
  } exp_t;

  alu_seq_shift_unit #(.WIDTH(8), .CNT_W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_in     (op_in),
    .a_in      (a_in),
    .b_in      (b_in),
    .c_in      (c_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .res_out   (res_out),
    .res_we    (res_we),
    .flags_out (flags_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int ovf8(input int s);
    return ((s > 127) || (s < -128)) ? 1 : 0;
  endfunction

  // Reference: whole-operation arithmetic on ints, rotations as ring rotates
  function automatic exp_t model(input int op, input int a, input int b, input int c);
    exp_t e;
    int r, cy, v, k, s, sa, sb, x;
    sa = (a >= 128) ? a - 256 : a;
    sb = (b >= 128) ? b - 256 : b;
    r = a; cy = c; v = 0; k = 0; e.we = 1'b1;
    case (op)
      0: begin s = a + b; r = s & 255; cy = s >> 8; v = ovf8(sa + sb); end
      1: begin s = a + b + c; r = s & 255; cy = s >> 8; v = ovf8(sa + sb + c); end
      2, 4: begin
        r = (a - b) & 255; cy = (a >= b) ? 1 : 0; v = ovf8(sa - sb);
        if (op == 4) e.we = 1'b0;
      end
      3: begin r = (a - b - (1 - c)) & 255; cy = (a >= b + 1 - c) ? 1 : 0; v = ovf8(sa - sb - (1 - c)); end
      5: r = a & b;
      6: r = a | b;
      7: r = a ^ b;
      8: begin k = (b > 8) ? 8 : b; if (k > 0) begin r = (a << k) & 255; cy = (a >> (8 - k)) & 1; end end
      9: begin k = (b > 8) ? 8 : b; if (k > 0) begin r = a >> k; cy = (a >> (k - 1)) & 1; end end
      10: begin k = (b > 8) ? 8 : b; if (k > 0) begin r = (sa >>> k) & 255; cy = (sa >>> (k - 1)) & 1; end end
      11: begin k = b % 8; if (k > 0) begin r = ((a << k) | (a >> (8 - k))) & 255; cy = r & 1; end end
      12: begin k = b % 8; if (k > 0) begin r = ((a >> k) | (a << (8 - k))) & 255; cy = (r >> 7) & 1; end end
      13: begin
        k = b % 9;
        if (k > 0) begin x = (c << 8) | a; x = ((x << k) | (x >> (9 - k))) & 511; r = x & 255; cy = x >> 8; end
      end
      14: begin
        k = b % 9;
        if (k > 0) begin x = (a << 1) | c; x = ((x >> k) | (x << (9 - k))) & 511; r = x >> 1; cy = x & 1; end
      end
      default: e.we = 1'b0;
    endcase
    e.r   = 8'(r);
    e.f   = {r[7], v[0], (r == 0), cy[0]};
    e.lat = 1 + k;
    return e;
  endfunction

  // Issue one op, wait for its result and compare against the given expectation
  task automatic run_op(input string tag, input int op, input int a, input int b, input int c,
                        input logic [7:0] er, input logic [3:0] ef, input logic ew, input int el);
    int n;
    int lat;
    @(negedge clk);
    n = 0;
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    check({tag, ".rdy"}, 32'(in_ready), 32'd1);
    op_in = 4'(op); a_in = 8'(a); b_in = 8'(b); c_in = c[0];
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 40) begin @(negedge clk); lat++; end
    check({tag, ".lat"}, 32'(lat), 32'(el));
    check({tag, ".res"}, 32'(res_out), 32'(er));
    check({tag, ".flg"}, 32'(flags_out), 32'(ef));
    check({tag, ".we"}, 32'(res_we), 32'(ew));
  endtask

  task automatic run_model(input string tag, input int op, input int a, input int b, input int c);
    exp_t e;
    e = model(op, a, b, c);
    run_op(tag, op, a, b, c, e.r, e.f, e.we, e.lat);
  endtask

  initial begin
    exp_t q_exp[3];
    int q_op[3], q_a[3], q_b[3], q_c[3];
    logic [7:0] got_r[$];
    logic [3:0] got_f[$];
    int idx, extra;

    total = 0; bad = 0;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    op_in = '0; a_in = '0; b_in = '0; c_in = 1'b0;

    #12;
    check("rst.in_ready", 32'(in_ready), 32'd1);
    check("rst.out_valid", 32'(out_valid), 32'd0);
    check("rst.res", 32'(res_out), 32'd0);
    check("rst.we", 32'(res_we), 32'd0);
    check("rst.flags", 32'(flags_out), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    run_op("add_ff_01", 0, 8'hFF, 8'h01, 0, 8'h00, 4'b0011, 1'b1, 1);
    run_op("sub_80_01", 2, 8'h80, 8'h01, 0, 8'h7F, 4'b0101, 1'b1, 1);
    run_op("cmp_05_05", 4, 8'h05, 8'h05, 0, 8'h00, 4'b0011, 1'b0, 1);
    run_op("lsl_81_3",  8, 8'h81, 3,     0, 8'h08, 4'b0000, 1'b1, 4);
    run_op("asr_80_200", 10, 8'h80, 200, 0, 8'hFF, 4'b1001, 1'b1, 9);
    run_op("rorc_b1",  14, 8'h01, 1,     0, 8'h00, 4'b0011, 1'b1, 2);
    run_op("rorc_b10", 14, 8'h01, 10,    0, 8'h00, 4'b0011, 1'b1, 2);
    run_op("rsvd_15",  15, 8'h00, 8'h55, 1, 8'h00, 4'b0011, 1'b0, 1);
    run_op("rol_96_8", 11, 8'h96, 8,     1, 8'h96, 4'b1001, 1'b1, 1);

    // Reset during the third SHIFT cycle of a long lsr
    @(negedge clk);
    op_in = 4'd9; a_in = 8'hF0; b_in = 8'd8; c_in = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("rstmid.out_valid", 32'(out_valid), 32'd0);
    check("rstmid.flags", 32'(flags_out), 32'd0);
    check("rstmid.in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rstmid.idle_rdy", 32'(in_ready), 32'd1);
    check("rstmid.no_out", 32'(out_valid), 32'd0);
    run_op("add_after_rst", 0, 8'h02, 8'h03, 0, 8'h05, 4'b0000, 1'b1, 1);

    // Backpressure: result held stable while out_ready is low
    @(negedge clk);
    out_ready = 1'b0;
    op_in = 4'd0; a_in = 8'h70; b_in = 8'h10; c_in = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("bp.valid", 32'(out_valid), 32'd1);
      check("bp.res", 32'(res_out), 32'h80);
      check("bp.flags", 32'(flags_out), 32'hC);
      check("bp.in_ready", 32'(in_ready), 32'd0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("bp.rdy_after", 32'(in_ready), 32'd1);
    check("bp.valid_after", 32'(out_valid), 32'd0);

    // Back-to-back: in_valid held high across three queued ops
    q_op = '{5, 7, 9}; q_a = '{8'hF0, 8'hAA, 8'h03}; q_b = '{8'h3C, 8'hAA, 2}; q_c = '{1, 0, 0};
    for (int i = 0; i < 3; i++) q_exp[i] = model(q_op[i], q_a[i], q_b[i], q_c[i]);
    idx = 0;
    op_in = 4'(q_op[0]); a_in = 8'(q_a[0]); b_in = 8'(q_b[0]); c_in = q_c[0][0];
    in_valid = 1'b1;
    for (int cyc = 0; cyc < 200 && got_r.size() < 3; cyc++) begin
      if (out_valid) begin got_r.push_back(res_out); got_f.push_back(flags_out); end
      if (in_ready && idx < 3) begin
        @(posedge clk);
        idx++;
        #1;
        if (idx < 3) begin
          op_in = 4'(q_op[idx]); a_in = 8'(q_a[idx]); b_in = 8'(q_b[idx]); c_in = q_c[idx][0];
        end else begin
          in_valid = 1'b0;
        end
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    extra = 0;
    for (int i = 0; i < 5; i++) begin
      if (out_valid) extra++;
      @(negedge clk);
    end
    check("b2b.accepted", 32'(idx), 32'd3);
    check("b2b.count", 32'(got_r.size()), 32'd3);
    check("b2b.extra", 32'(extra), 32'd0);
    for (int i = 0; i < 3; i++) begin
      if (i < got_r.size()) begin
        check($sformatf("b2b.res%0d", i), 32'(got_r[i]), 32'(q_exp[i].r));
        check($sformatf("b2b.flg%0d", i), 32'(got_f[i]), 32'(q_exp[i].f));
      end
    end

    // Randomized ops, small counts favoured so shift boundaries get exercised
    for (int i = 0; i < 80; i++) begin
      int op, a, b, c;
      op = int'($urandom_range(0, 15));
      a  = int'($urandom_range(0, 255));
      b  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 18));
      c  = int'($urandom_range(0, 1));
      run_model($sformatf("rnd%0d_op%0d_a%0h_b%0h_c%0d", i, op, a, b, c), op, a, b, c);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_seq_shift_unit.md
Name: alu_seq_shift_unit

Overview:
- Parametrised successor to the 8-bit ALU op set: one WIDTH-bit execution unit with valid/ready handshakes on input and output.
- Implements the full 15-op ALU instruction set.
- Arithmetic and logic ops complete in one cycle. Shift and rotate ops iterate one bit position per cycle on a small datapath, so no barrel shifter is needed.
- Sits between the decode stage (operand issue) and register writeback; consumes and produces the flag register.

Parameters:
- WIDTH, 8, operand/result width in bits; must be a power of two, >= 4.
- CNT_W, 8, width of b_in field used as shift/rotate count (count taken from b_in[CNT_W-1:0]).

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous active-high reset
- in_valid  in  1  operands/op valid
- in_ready  out  1  unit can accept (high only in IDLE)
- op_in  in  4  opcode: add=0 adc=1 sub=2 sbc=3 cmp=4 and=5 orr=6 xor=7 lsl=8 lsr=9 asr=10 rol=11 ror=12 rolc=13 rorc=14; 15 reserved
- a_in  in  WIDTH  operand A
- b_in  in  WIDTH  operand B / count
- c_in  in  1  incoming carry flag
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- res_out  out  WIDTH  result
- res_we  out  1  result should be written back (0 for cmp)
- flags_out  out  4  {N,V,Z,C}

Behaviour:
- Reset, asynchronous: state=IDLE; in_ready=1; out_valid=0; res_out=0; res_we=0; flags_out=0; internal count=0.
- Reset mid-operation aborts the op; no output is produced.
- FSM states are IDLE, SHIFT and DONE.
- IDLE: a transfer occurs when in_valid && in_ready. The unit latches op, a, b and c.
  - Op not a shift/rotate, or effective count 0: next state is DONE.
  - Otherwise: next state is SHIFT with count = effective count.
- SHIFT: each cycle moves one bit position, updates the carry shadow, and decrements count. When count reaches 0, next state is DONE.
- DONE: out_valid=1. Outputs are held stable until out_ready. On out_valid && out_ready, next state is IDLE.
  - in_ready rises the cycle after the output handshake; there is no same-cycle reissue.
- Latency from accept edge to out_valid: 1 cycle for single-cycle ops; 1+k cycles for shifts/rotates, where k = effective count.
- Arithmetic:
  - add = a+b.
  - adc = a+b+c.
  - sub = a-b.
  - sbc = a-b-!c.
  - cmp computes sub with res_we=0. All other ops have res_we=1.
  - C = carry out; for subtraction C=1 means no borrow.
  - V = signed overflow.
- Logic ops (and, orr, xor): C=c_in, V=0.
- Effective count:
  - lsl, lsr, asr: min(b, WIDTH).
  - rol, ror: b mod WIDTH.
  - rolc, rorc: b mod (WIDTH+1); the carry acts as an extra bit, at bit WIDTH for rolc and below bit 0 for rorc.
- Shift fill: lsl and lsr fill with 0; asr replicates the MSB.
- Shift/rotate flags:
  - C = last bit shifted or rotated out (for rolc/rorc: final carry bit).
  - Count 0: result=a, C=c_in.
  - V=0 for all shift/rotate ops.
- All ops: N = res[WIDTH-1]; Z = (res==0).
- Reserved op 15: result=a, C=c_in, V=0, res_we=0, 1-cycle latency.
- in_valid while busy is ignored. The upstream holds its operands until in_ready is high.

Test Plan (WIDTH=8):
- add a=0xFF b=0x01 c=0 -> res=0x00, N=0 V=0 Z=1 C=1, out_valid 1 cycle after accept; sub a=0x80 b=0x01 -> 0x7F, V=1 C=1; cmp a=0x05 b=0x05 -> Z=1 C=1, res_we=0.
- lsl a=0x81 b=3 -> res=0x08, C=0, out_valid 4 cycles after accept; asr a=0x80 b=200 -> count saturates to 8, res=0xFF C=1, latency 9.
- rorc a=0x01 c=0 b=1 -> res=0x00 C=1, latency 2; same with b=10 (10 mod 9 = 1) -> identical result and latency; rol a=0x96 b=8 -> count 0, res=0x96 C=c_in, latency 1.
- Backpressure: complete add, hold out_ready=0 for 5 cycles -> out_valid, res_out and flags stable, in_ready=0; assert out_ready -> in_ready=1 next cycle.
- Reset mid-op: issue lsr a=0xF0 b=8, assert reset in 3rd SHIFT cycle -> out_valid=0, flags_out=0 immediately; after release in_ready=1, and a new add 0x02+0x03 returns 0x05.
- Back-to-back: in_valid held high with 3 queued ops (and, xor, lsr b=2) -> each accepted only when in_ready=1, results in order, no op dropped or duplicated.
